screen_painter: RTL and testbench

//  Full-screen raster sequencer that sits downstream of the screen select

---
 rtl/screen_painter.sv | 199 +++++++++++++++++++
 tb/tb_screen_painter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_painter.sv
// screen_painter: full-screen raster sequencer between the screen select
// logic and the VGA adapter.
//
// On an accepted start the block latches the screen index and black flag,
// walks every pixel of a WIDTH x HEIGHT frame in raster order (x fastest),
// issues one ROM address per cycle, delays the pixel coordinates by the ROM
// read latency so they line up with rom_color, and strobes one plot per
// pixel. A single-cycle done pulse follows the last plot.
//
// Ports
//   clk, resetn            rising-edge clock, asynchronous active-low reset
//   start                  paint request, only looked at in IDLE
//   screen_in, black_in    screen index / black flag captured on start
//   memorySel, black       latched screen index / black flag to the colour mux
//   rom_addr               pixel address y*WIDTH+x, one per scan cycle
//   rom_color              mux colour, valid RD_LAT cycles after rom_addr
//   vga_x/y/colour/plot    plot interface to the VGA adapter
//   busy, done             frame in progress / completion pulse
//   state_dbg              current FSM state (IDLE=0 SCAN=1 DRAIN=2 DONE=3)
//
// Handshake: this block has no back-pressure. start is a level request that
// is accepted on the first IDLE cycle it is seen high; vga_plot is a one-cycle
// write strobe that the adapter must accept unconditionally.
module screen_painter #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [6:0]        screen_in,
    input  logic              black_in,
    output logic [6:0]        memorySel,
    output logic              black,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_color,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          sel_q, sel_d;
    logic                black_q, black_d;
    logic [7:0]          x_q, x_d;
    logic [6:0]          y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [7:0]          px_q [RD_LAT];
    logic [7:0]          px_d [RD_LAT];
    logic [6:0]          py_q [RD_LAT];
    logic [6:0]          py_d [RD_LAT];
    logic [2:0]          col_q, col_d;

    logic                issue;
    logic                last_pix;
    logic                plot;
    logic [2:0]          col_now;

    assign issue    = (state_q == S_SCAN);
    assign last_pix = (x_q == 8'(WIDTH - 1)) && (y_q == 7'(HEIGHT - 1));
    assign plot     = vld_q[RD_LAT-1];
    assign col_now  = black_q ? 3'd0 : rom_color;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        black_d = black_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // Valid pipe shifts every cycle; bit 0 is the address issued now.
        vld_d   = (vld_q << 1) | RD_LAT'(issue);
        // Coordinate stages only load when a valid pixel enters them, so the
        // last stage keeps the previous plot's coordinates between plots.
        for (int i = 0; i < RD_LAT; i++) begin
            px_d[i] = px_q[i];
            py_d[i] = py_q[i];
            if (i == 0) begin
                if (issue) begin
                    px_d[i] = x_q;
                    py_d[i] = y_q;
                end
            end else if (vld_q[i-1]) begin
                px_d[i] = px_q[i-1];
                py_d[i] = py_q[i-1];
            end
        end
        col_d = plot ? col_now : col_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    sel_d   = screen_in;
                    black_d = black_in;
                    x_d     = 8'd0;
                    y_d     = 7'd0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SCAN: begin
                // The final address stays on rom_addr; the counter never
                // steps past WIDTH*HEIGHT-1.
                if (last_pix) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (x_q == 8'(WIDTH - 1)) begin
                        x_d = 8'd0;
                        y_d = y_q + 7'd1;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once only the last stage (plotting this cycle) is
                // occupied, so done lands right after the final plot.
                if (vld_d == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sel_q   <= 7'd0;
            black_q <= 1'b0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            col_q   <= 3'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                px_q[i] <= 8'd0;
                py_q[i] <= 7'd0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            black_q <= black_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            col_q   <= col_d;
            for (int i = 0; i < RD_LAT; i++) begin
                px_q[i] <= px_d[i];
                py_q[i] <= py_d[i];
            end
        end
    end

    assign memorySel  = sel_q;
    assign black      = black_q;
    assign rom_addr   = addr_q;
    assign vga_x      = px_q[RD_LAT-1];
    assign vga_y      = py_q[RD_LAT-1];
    // Colour is taken straight from the ROM on a plot cycle and held otherwise.
    assign vga_colour = plot ? col_now : col_q;
    assign vga_plot   = plot;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_screen_painter.sv
module tb_screen_painter;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int N  = W * H;
    localparam int AW = 15;

    typedef struct {
        int k;
        int x;
        int y;
        int c;
    } vec_t;

    logic clk;
    logic resetn;
    logic start;
    logic [6:0] screen_in;
    logic black_in;
    logic rom_mode;

    // index 0: RD_LAT=1 instance, index 1: RD_LAT=3 instance
    logic [6:0]    msel  [2];
    logic          blk   [2];
    logic [AW-1:0] raddr [2];
    logic [2:0]    rcol  [2];
    logic [7:0]    vx    [2];
    logic [6:0]    vy    [2];
    logic [2:0]    vc    [2];
    logic          plot  [2];
    logic          busy  [2];
    logic          done  [2];
    logic [1:0]    st    [2];

    int checks;
    int errors;
    int cyc;
    int base;
    logic mon_en;
    logic exp_black;
    int pcnt [2];
    int bad  [2];
    int dcnt [2];
    int dcyc [2];
    int amax [2];
    logic [7:0] cap_x [2][N];
    logic [6:0] cap_y [2][N];
    logic [2:0] cap_c [2][N];
    vec_t tbl [7];
    int lat [2];

    screen_painter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .screen_in(screen_in),
        .black_in(black_in), .memorySel(msel[0]), .black(blk[0]),
        .rom_addr(raddr[0]), .rom_color(rcol[0]), .vga_x(vx[0]), .vga_y(vy[0]),
        .vga_colour(vc[0]), .vga_plot(plot[0]), .busy(busy[0]), .done(done[0]),
        .state_dbg(st[0])
    );

    screen_painter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .start(start), .screen_in(screen_in),
        .black_in(black_in), .memorySel(msel[1]), .black(blk[1]),
        .rom_addr(raddr[1]), .rom_color(rcol[1]), .vga_x(vx[1]), .vga_y(vy[1]),
        .vga_colour(vc[1]), .vga_plot(plot[1]), .busy(busy[1]), .done(done[1]),
        .state_dbg(st[1])
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: colour = addr[2:0] (or 3'b111 in black mode), delayed by
    // the read latency of each instance
    logic [2:0] rom1_q;
    logic [2:0] rom3_q [3];
    always @(posedge clk) begin
        rom1_q    <= rom_mode ? 3'b111 : raddr[0][2:0];
        rom3_q[0] <= rom_mode ? 3'b111 : raddr[1][2:0];
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign rcol[0] = rom1_q;
    assign rcol[1] = rom3_q[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor / scoreboard: compares every plot to the raster model
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (plot[d]) begin
                    if (pcnt[d] < N) begin
                        cap_x[d][pcnt[d]] = vx[d];
                        cap_y[d][pcnt[d]] = vy[d];
                        cap_c[d][pcnt[d]] = vc[d];
                        if (vx[d] != 8'(pcnt[d] % W) || vy[d] != 7'(pcnt[d] / W) ||
                            vc[d] != (exp_black ? 3'd0 : 3'(pcnt[d])))
                            bad[d]++;
                    end else begin
                        bad[d]++;
                    end
                    pcnt[d]++;
                end
                if (done[d]) begin
                    dcnt[d]++;
                    dcyc[d] = cyc - base;
                end
                if (int'(raddr[d]) > amax[d]) amax[d] = int'(raddr[d]);
            end
        end
    end

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            pcnt[d] = 0;
            bad[d]  = 0;
            dcnt[d] = 0;
            dcyc[d] = -1;
            amax[d] = 0;
        end
    endtask

    // raise start for edge 0; returns just after edge 0 with monitoring on
    task automatic launch(input logic [6:0] scr, input logic bk);
        @(negedge clk);
        screen_in = scr;
        black_in  = bk;
        rom_mode  = bk;
        exp_black = bk;
        start     = 1'b1;
        base      = cyc;
        clear_mon();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        start  = 1'b0;
    endtask

    task automatic check_table(input int d, input logic bk, input string tag);
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].k < pcnt[d]) begin
                check($sformatf("%s_d%0d_x_k%0d", tag, d, tbl[i].k), cap_x[d][tbl[i].k], tbl[i].x);
                check($sformatf("%s_d%0d_y_k%0d", tag, d, tbl[i].k), cap_y[d][tbl[i].k], tbl[i].y);
                check($sformatf("%s_d%0d_c_k%0d", tag, d, tbl[i].k), cap_c[d][tbl[i].k],
                      bk ? 0 : tbl[i].c);
            end
        end
    endtask

    task automatic run_scan(input logic [6:0] scr, input logic bk, input logic pulse,
                            input string tag);
        launch(scr, bk);
        @(negedge clk); // cycle 1
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_busy_c1", tag, d), busy[d], 1);
            check($sformatf("%s_d%0d_msel_c1", tag, d), msel[d], scr);
            check($sformatf("%s_d%0d_black_c1", tag, d), blk[d], bk);
            check($sformatf("%s_d%0d_addr_c1", tag, d), raddr[d], 0);
        end
        for (int c = 2; c <= N + 10; c++) begin
            @(negedge clk);
            if (pulse && c == 500) begin
                screen_in = 7'd9;
                start     = 1'b1;
            end
            if (pulse && c == 501) start = 1'b0;
        end
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_plots", tag, d), pcnt[d], N);
            check($sformatf("%s_d%0d_model_mism", tag, d), bad[d], 0);
            check($sformatf("%s_d%0d_done_cnt", tag, d), dcnt[d], 1);
            check($sformatf("%s_d%0d_done_cyc", tag, d), dcyc[d], N + lat[d] + 1);
            check($sformatf("%s_d%0d_addr_max", tag, d), amax[d], N - 1);
            check($sformatf("%s_d%0d_msel_end", tag, d), msel[d], scr);
            check($sformatf("%s_d%0d_black_end", tag, d), blk[d], bk);
            check($sformatf("%s_d%0d_busy_end", tag, d), busy[d], 0);
            check_table(d, bk, tag);
        end
    endtask

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        screen_in = 7'd0;
        black_in  = 1'b0;
        rom_mode  = 1'b0;
        exp_black = 1'b0;
        mon_en    = 1'b0;
        base      = 0;
        lat[0]    = 1;
        lat[1]    = 3;
        clear_mon();

        // pixel index, x, y, colour (= index mod 8)
        tbl[0] = '{0,     0,   0,   0};
        tbl[1] = '{1,     1,   0,   1};
        tbl[2] = '{159,   159, 0,   7};
        tbl[3] = '{160,   0,   1,   0};
        tbl[4] = '{161,   1,   1,   1};
        tbl[5] = '{7000,  120, 43,  0};
        tbl[6] = '{19199, 159, 119, 7};

        // reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_d%0d_msel", d), msel[d], 0);
            check($sformatf("rst_d%0d_black", d), blk[d], 0);
            check($sformatf("rst_d%0d_addr", d), raddr[d], 0);
            check($sformatf("rst_d%0d_vx", d), vx[d], 0);
            check($sformatf("rst_d%0d_vy", d), vy[d], 0);
            check($sformatf("rst_d%0d_vc", d), vc[d], 0);
            check($sformatf("rst_d%0d_plot", d), plot[d], 0);
            check($sformatf("rst_d%0d_busy", d), busy[d], 0);
            check($sformatf("rst_d%0d_done", d), done[d], 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // screen 3 with a stray start at cycle 500 that must be ignored
        run_scan(7'd3, 1'b0, 1'b1, "scan");
        // black frame, ROM returns all ones
        run_scan(7'd5, 1'b1, 1'b0, "black");

        // reset in the middle of a frame
        launch(7'd3, 1'b0);
        for (int c = 0; c < 8000 && pcnt[0] < 7000; c++) @(negedge clk);
        check("midrst_reached", (pcnt[0] >= 7000) ? 1 : 0, 1);
        #2;
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_d%0d_plot", d), plot[d], 0);
            check($sformatf("midrst_d%0d_busy", d), busy[d], 0);
            check($sformatf("midrst_d%0d_addr", d), raddr[d], 0);
            check($sformatf("midrst_d%0d_msel", d), msel[d], 0);
        end
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_d%0d_no_done", d), dcnt[d], 0);
            check($sformatf("midrst_d%0d_model_mism", d), bad[d], 0);
        end
        mon_en = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // repaint after reset restarts from (0,0)
        launch(7'd3, 1'b0);
        repeat (300) @(negedge clk);
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("repaint_d%0d_plots", d), (pcnt[d] > 200) ? 1 : 0, 1);
            check($sformatf("repaint_d%0d_model_mism", d), bad[d], 0);
            check($sformatf("repaint_d%0d_busy", d), busy[d], 1);
            check_table(d, 1'b0, "repaint");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
